// File: rtl/freecell_move_decoder_pkg.sv
// Shared notation for the FreeCell move decoder: location codes, the ASCII
// characters the decoder understands, the FSM state type and the per-character
// classification record produced by the character decoder.
package freecell_move_decoder_pkg;

    // Location codes understood by freecellPlayer
    localparam logic [3:0] LOC_TAB0  = 4'b0000;
    localparam logic [3:0] LOC_TAB1  = 4'b0001;
    localparam logic [3:0] LOC_TAB2  = 4'b0010;
    localparam logic [3:0] LOC_TAB3  = 4'b0011;
    localparam logic [3:0] LOC_TAB4  = 4'b0100;
    localparam logic [3:0] LOC_TAB5  = 4'b0101;
    localparam logic [3:0] LOC_TAB6  = 4'b0110;
    localparam logic [3:0] LOC_TAB7  = 4'b0111;
    localparam logic [3:0] LOC_FREE0 = 4'b1000;
    localparam logic [3:0] LOC_FREE1 = 4'b1001;
    localparam logic [3:0] LOC_FREE2 = 4'b1010;
    localparam logic [3:0] LOC_FREE3 = 4'b1011;
    localparam logic [3:0] LOC_HOME  = 4'b1100;
    localparam logic [3:0] LOC_NOP   = 4'b1111;

    // ASCII characters recognised by the decoder
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_TAB0  = 8'h31;  // '1'
    localparam logic [7:0] CH_TAB7  = 8'h38;  // '8'
    localparam logic [7:0] CH_FREE0 = 8'h61;  // 'a'
    localparam logic [7:0] CH_FREE3 = 8'h64;  // 'd'
    localparam logic [7:0] CH_HOME  = 8'h68;  // 'h'

    // Decoder FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HAVE_SRC = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WON      = 2'd3
    } state_t;

    // Classification of one input character
    typedef struct packed {
        logic       is_ws;
        logic       ok_src;
        logic       ok_dst;
        logic [3:0] loc;
    } char_info_t;

endpackage

// File: rtl/freecell_move_decoder_if.sv
// Character stream handshake into the move decoder: one ASCII byte is
// transferred on each clock edge where in_valid and in_ready are both high.
interface freecell_move_decoder_if;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;

    // Character producer side
    modport master (
        output in_char,
        output in_valid,
        input  in_ready
    );

    // Decoder side
    modport slave (
        input  in_char,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/freecell_char_decode.sv
// Purely combinational classifier: turns one ASCII character into whitespace /
// legal-source / legal-destination flags plus the matching location code.
// Tableau and free-cell characters may be either end of a move; home is only
// ever a destination.
module freecell_char_decode
    import freecell_move_decoder_pkg::*;
(
    input  logic [7:0] in_char,
    output logic       is_ws,
    output logic       ok_src,
    output logic       ok_dst,
    output logic [3:0] loc
);

    logic [7:0] tab_offset;
    logic [7:0] free_offset;
    char_info_t info;

    assign tab_offset  = in_char - CH_TAB0;
    assign free_offset = in_char - CH_FREE0;

    // Classify the character and derive its location code from its offset
    always_comb begin
        info     = '0;
        info.loc = LOC_NOP;
        if ((in_char == CH_SPACE) || (in_char == CH_CR) || (in_char == CH_LF)) begin
            info.is_ws = 1'b1;
        end else if ((in_char >= CH_TAB0) && (in_char <= CH_TAB7)) begin
            info.ok_src = 1'b1;
            info.ok_dst = 1'b1;
            info.loc    = {1'b0, tab_offset[2:0]};
        end else if ((in_char >= CH_FREE0) && (in_char <= CH_FREE3)) begin
            info.ok_src = 1'b1;
            info.ok_dst = 1'b1;
            info.loc    = {2'b10, free_offset[1:0]};
        end else if (in_char == CH_HOME) begin
            info.ok_dst = 1'b1;
            info.loc    = LOC_HOME;
        end
    end

    assign is_ws  = info.is_ws;
    assign ok_src = info.ok_src;
    assign ok_dst = info.ok_dst;
    assign loc    = info.loc;

endmodule

// File: rtl/freecell_move_decoder.sv
// Command stage in front of freecellPlayer. Parses a stream of two-character
// moves "<src><dst>" and presents each complete move on source/dest for
// exactly one clock, with NOP on every other cycle. Counts issued moves
// (saturating) and freezes input once the player reports a win.
module freecell_move_decoder
    import freecell_move_decoder_pkg::*;
#(
    parameter int         MOVE_COUNT_BITS = 10,
    parameter logic [3:0] NOP_CODE        = 4'b1111
) (
    input  logic                       clock,
    input  logic                       reset,
    freecell_move_decoder_if.slave     char_if,
    input  logic                       win,
    output logic [3:0]                 source,
    output logic [3:0]                 dest,
    output logic                       move_strobe,
    output logic                       bad_char,
    output logic                       done,
    output logic [MOVE_COUNT_BITS-1:0] move_count
);

    localparam logic [MOVE_COUNT_BITS-1:0] COUNT_MAX = {MOVE_COUNT_BITS{1'b1}};
    localparam logic [MOVE_COUNT_BITS-1:0] COUNT_ONE = {{(MOVE_COUNT_BITS-1){1'b0}}, 1'b1};

    logic       is_ws;
    logic       ok_src;
    logic       ok_dst;
    logic [3:0] loc;
    logic       accept;

    state_t                     state_q,  state_d;
    logic [3:0]                 src_q,    src_d;
    logic [3:0]                 source_q, source_d;
    logic [3:0]                 dest_q,   dest_d;
    logic                       strobe_q, strobe_d;
    logic                       bad_q,    bad_d;
    logic                       done_q,   done_d;
    logic                       ready_q,  ready_d;
    logic [MOVE_COUNT_BITS-1:0] count_q,  count_d;

    freecell_char_decode u_char_decode (
        .in_char (char_if.in_char),
        .is_ws   (is_ws),
        .ok_src  (ok_src),
        .ok_dst  (ok_dst),
        .loc     (loc)
    );

    // in_ready is itself a flop, so a transfer only depends on registered state
    assign accept = char_if.in_valid & ready_q;

    // Next-state logic: parse the accepted character and form all next outputs
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        source_d = NOP_CODE;
        dest_d   = NOP_CODE;
        strobe_d = 1'b0;
        bad_d    = 1'b0;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (win) begin
                    state_d = ST_WON;
                end else if (accept && !is_ws) begin
                    if (ok_src) begin
                        src_d   = loc;
                        state_d = ST_HAVE_SRC;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_HAVE_SRC: begin
                if (win) begin
                    src_d   = '0;
                    state_d = ST_WON;
                end else if (accept && !is_ws) begin
                    if (ok_dst) begin
                        source_d = src_q;
                        dest_d   = loc;
                        strobe_d = 1'b1;
                        count_d  = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_ONE;
                        state_d  = ST_ISSUE;
                    end else begin
                        bad_d   = 1'b1;
                        src_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                src_d   = '0;
                state_d = win ? ST_WON : ST_IDLE;
            end
            ST_WON: begin
                state_d = ST_WON;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d  = (state_d == ST_WON);
        ready_d = (state_d == ST_IDLE) || (state_d == ST_HAVE_SRC);
    end

    // State, output and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            source_q <= NOP_CODE;
            dest_q   <= NOP_CODE;
            strobe_q <= 1'b0;
            bad_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            source_q <= source_d;
            dest_q   <= dest_d;
            strobe_q <= strobe_d;
            bad_q    <= bad_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            count_q  <= count_d;
        end
    end

    assign char_if.in_ready = ready_q;
    assign source           = source_q;
    assign dest             = dest_q;
    assign move_strobe      = strobe_q;
    assign bad_char         = bad_q;
    assign done             = done_q;
    assign move_count       = count_q;

endmodule
